// File: rtl/lbdr_pkg.sv
// Shared definitions for the LBDR router slice.
//   - flit type encodings (one-hot)
//   - output port indices into port_req {L,S,W,E,N}; N/E/W/S indices double
//     as bit positions in the connectivity vector {Cs,Cw,Ce,Cn}
//   - bit positions inside the routing vector {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   - FSM state encoding
// Optional feature macro used by lbdr_param: LBDR_DEROUTE_EN.
package lbdr_pkg;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;

    localparam int RXY_NE = 0;
    localparam int RXY_NW = 1;
    localparam int RXY_EN = 2;
    localparam int RXY_ES = 3;
    localparam int RXY_WN = 4;
    localparam int RXY_WS = 5;
    localparam int RXY_SE = 6;
    localparam int RXY_SW = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } lbdr_state_e;

endpackage

// File: rtl/lbdr_route_calc.sv
// Combinational LBDR minimal-route computation.
// Ports:
//   cur_addr_i  router address {y,x}
//   dst_addr_i  destination address {y,x}
//   rxy_i       routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   cx_i        connectivity bits {Cs,Cw,Ce,Cn}
//   port_req_o  candidate ports {L,S,W,E,N}; all zero means unroutable
module lbdr_route_calc
    import lbdr_pkg::*;
#(
    parameter int  X_W    = 2,
    parameter int  Y_W    = 2,
    localparam int ADDR_W = X_W + Y_W
) (
    input  logic [ADDR_W-1:0] cur_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [7:0]        rxy_i,
    input  logic [3:0]        cx_i,
    output logic [4:0]        port_req_o
);

    logic [X_W-1:0] x_cur;
    logic [X_W-1:0] x_dst;
    logic [Y_W-1:0] y_cur;
    logic [Y_W-1:0] y_dst;
    logic           n1;
    logic           s1;
    logic           e1;
    logic           w1;

    assign x_cur = cur_addr_i[X_W-1:0];
    assign x_dst = dst_addr_i[X_W-1:0];
    assign y_cur = cur_addr_i[ADDR_W-1:X_W];
    assign y_dst = dst_addr_i[ADDR_W-1:X_W];

    // North is toward smaller y, east toward larger x.
    assign n1 = (y_dst < y_cur);
    assign s1 = (y_cur < y_dst);
    assign e1 = (x_cur < x_dst);
    assign w1 = (x_dst < x_cur);

    always_comb begin
        port_req_o = '0;
        port_req_o[PORT_N] = ((n1 & ~e1 & ~w1) |
                              (n1 &  e1 & rxy_i[RXY_NE]) |
                              (n1 &  w1 & rxy_i[RXY_NW])) & cx_i[PORT_N];
        port_req_o[PORT_E] = ((e1 & ~n1 & ~s1) |
                              (e1 &  n1 & rxy_i[RXY_EN]) |
                              (e1 &  s1 & rxy_i[RXY_ES])) & cx_i[PORT_E];
        port_req_o[PORT_W] = ((w1 & ~n1 & ~s1) |
                              (w1 &  n1 & rxy_i[RXY_WN]) |
                              (w1 &  s1 & rxy_i[RXY_WS])) & cx_i[PORT_W];
        port_req_o[PORT_S] = ((s1 & ~e1 & ~w1) |
                              (s1 &  e1 & rxy_i[RXY_SE]) |
                              (s1 &  w1 & rxy_i[RXY_SW])) & cx_i[PORT_S];
        port_req_o[PORT_L] = ~n1 & ~e1 & ~w1 & ~s1;
    end

endmodule

// File: rtl/lbdr_param.sv
// LBDR routing controller: configuration registers plus packet FSM.
// Latches the output port when a header arrives and holds it until the tail
// flit is consumed. Unroutable headers are dropped (or, when LBDR_DEROUTE_EN
// is defined, sent to the configured deroute port if it is connected).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   empty_i            input FIFO empty; flit fields invalid when 1
//   flit_id_i          flit type HEADER/BODY/TAIL
//   dst_addr_i         destination {y,x}, valid with HEADER
//   rd_en_i            current flit consumed this cycle
//   cfg_we_i           configuration write strobe (honoured in IDLE only)
//   cfg_rxy_i          routing bits
//   cfg_cx_i           connectivity bits
//   cfg_dr_i           deroute port 0=N 1=E 2=W 3=S
//   cfg_cur_addr_i     router address
//   port_req_o         registered {L,S,W,E,N} request
//   route_valid_o      port_req_o valid for current packet
//   discard_o          packet being dropped
//   drop_o             one-cycle pulse on unroutable header
//   err_o              sticky protocol error
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for a header; config writes accepted
// ST_ROUTE | port latched, holding until tail is consumed
// ST_DROP  | discarding packet until tail is consumed
module lbdr_param
    import lbdr_pkg::*;
#(
    parameter int                X_W          = 2,
    parameter int                Y_W          = 2,
    localparam int               ADDR_W       = X_W + Y_W,
    parameter logic [7:0]        RXY_RST      = 8'd60,
    parameter logic [3:0]        CX_RST       = 4'hF,
    parameter logic [ADDR_W-1:0] CUR_ADDR_RST = ADDR_W'(5),
    parameter logic [1:0]        DR_RST       = 2'd0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              empty_i,
    input  logic [2:0]        flit_id_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic              rd_en_i,
    input  logic              cfg_we_i,
    input  logic [7:0]        cfg_rxy_i,
    input  logic [3:0]        cfg_cx_i,
    input  logic [1:0]        cfg_dr_i,
    input  logic [ADDR_W-1:0] cfg_cur_addr_i,
    output logic [4:0]        port_req_o,
    output logic              route_valid_o,
    output logic              discard_o,
    output logic              drop_o,
    output logic              err_o
);

    lbdr_state_e       state_q, state_d;
    logic [4:0]        port_req_q, port_req_d;
    logic              route_valid_q, route_valid_d;
    logic              discard_q, discard_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;

    logic [7:0]        rxy_q, rxy_d;
    logic [3:0]        cx_q, cx_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

    logic [4:0]        min_req;
    logic [4:0]        deroute_req;
    logic              deroute_ok;

    logic              hdr_in;
    logic              body_tail_in;
    logic              tail_pop;

    // Route uses the registered config, so a header arriving with cfg_we
    // routes with the old values.
    lbdr_route_calc #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_route_calc (
        .cur_addr_i (cur_addr_q),
        .dst_addr_i (dst_addr_i),
        .rxy_i      (rxy_q),
        .cx_i       (cx_q),
        .port_req_o (min_req)
    );

`ifdef LBDR_DEROUTE_EN
    logic [1:0] dr_q, dr_d;

    always_comb begin
        dr_d = dr_q;
        if (cfg_we_i && (state_q == ST_IDLE)) begin
            dr_d = cfg_dr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dr_q <= DR_RST;
        end else begin
            dr_q <= dr_d;
        end
    end

    // Deroute port index matches the Cx bit position, so one index serves both.
    always_comb begin
        deroute_req        = '0;
        deroute_req[dr_q]  = 1'b1;
        deroute_ok         = cx_q[dr_q];
    end
`else
    logic unused_dr;

    assign unused_dr   = ^{cfg_dr_i, DR_RST};
    assign deroute_req = '0;
    assign deroute_ok  = 1'b0;
`endif

    assign hdr_in       = !empty_i && (flit_id_i == FLIT_HEADER);
    assign body_tail_in = !empty_i && ((flit_id_i == FLIT_BODY) || (flit_id_i == FLIT_TAIL));
    assign tail_pop     = !empty_i && (flit_id_i == FLIT_TAIL) && rd_en_i;

    always_comb begin
        rxy_d      = rxy_q;
        cx_d       = cx_q;
        cur_addr_d = cur_addr_q;
        if (cfg_we_i && (state_q == ST_IDLE)) begin
            rxy_d      = cfg_rxy_i;
            cx_d       = cfg_cx_i;
            cur_addr_d = cfg_cur_addr_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        port_req_d    = port_req_q;
        route_valid_d = route_valid_q;
        discard_d     = discard_q;
        drop_d        = 1'b0;
        err_d         = err_q;

        case (state_q)
            ST_IDLE: begin
                if (hdr_in) begin
                    if (|min_req) begin
                        state_d       = ST_ROUTE;
                        port_req_d    = min_req;
                        route_valid_d = 1'b1;
                    end else if (deroute_ok) begin
                        state_d       = ST_ROUTE;
                        port_req_d    = deroute_req;
                        route_valid_d = 1'b1;
                    end else begin
                        state_d   = ST_DROP;
                        drop_d    = 1'b1;
                        discard_d = 1'b1;
                    end
                end else if (body_tail_in) begin
                    err_d = 1'b1;
                end
            end
            ST_ROUTE: begin
                if (hdr_in) begin
                    err_d = 1'b1;
                end else if (tail_pop) begin
                    state_d       = ST_IDLE;
                    port_req_d    = '0;
                    route_valid_d = 1'b0;
                end
            end
            ST_DROP: begin
                if (hdr_in) begin
                    err_d = 1'b1;
                end else if (tail_pop) begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                port_req_d    = '0;
                route_valid_d = 1'b0;
                discard_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            port_req_q    <= '0;
            route_valid_q <= 1'b0;
            discard_q     <= 1'b0;
            drop_q        <= 1'b0;
            err_q         <= 1'b0;
            rxy_q         <= RXY_RST;
            cx_q          <= CX_RST;
            cur_addr_q    <= CUR_ADDR_RST;
        end else begin
            state_q       <= state_d;
            port_req_q    <= port_req_d;
            route_valid_q <= route_valid_d;
            discard_q     <= discard_d;
            drop_q        <= drop_d;
            err_q         <= err_d;
            rxy_q         <= rxy_d;
            cx_q          <= cx_d;
            cur_addr_q    <= cur_addr_d;
        end
    end

    assign port_req_o    = port_req_q;
    assign route_valid_o = route_valid_q;
    assign discard_o     = discard_q;
    assign drop_o        = drop_q;
    assign err_o         = err_q;

endmodule
